// File: rtl/pipeline_pkg.sv
// Shared opcodes, sequencer state encoding and register-usage decode for the
// 5-stage integer pipeline control.
package pipeline_pkg;

  localparam int unsigned NREGS = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned OPC_W = 7;

  localparam logic [OPC_W-1:0] R_TYPE  = 7'b0110011;
  localparam logic [OPC_W-1:0] I_TYPE  = 7'b0010011;
  localparam logic [OPC_W-1:0] STORE   = 7'b0100011;
  localparam logic [OPC_W-1:0] LOAD    = 7'b0000011;
  localparam logic [OPC_W-1:0] BRANCH  = 7'b1100011;
  localparam logic [OPC_W-1:0] JALR    = 7'b1100111;
  localparam logic [OPC_W-1:0] JAL     = 7'b1101111;
  localparam logic [OPC_W-1:0] AUIPC   = 7'b0010111;
  localparam logic [OPC_W-1:0] LUI     = 7'b0110111;
  localparam logic [OPC_W-1:0] FENCES  = 7'b0001111;
  localparam logic [OPC_W-1:0] SYSCALL = 7'b1110011;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2
  } state_e;

  typedef struct packed {
    logic rs1;
    logic rs2;
    logic rd;
  } reg_use_t;

  // Which register fields an opcode actually reads or writes.
  function automatic reg_use_t decode_use(input logic [OPC_W-1:0] opc);
    reg_use_t u;
    u = '0;
    case (opc)
      R_TYPE:  begin u.rs1 = 1'b1; u.rs2 = 1'b1; u.rd = 1'b1; end
      I_TYPE:  begin u.rs1 = 1'b1; u.rd  = 1'b1; end
      STORE:   begin u.rs1 = 1'b1; u.rs2 = 1'b1; end
      LOAD:    begin u.rs1 = 1'b1; u.rd  = 1'b1; end
      BRANCH:  begin u.rs1 = 1'b1; u.rs2 = 1'b1; end
      JALR:    begin u.rs1 = 1'b1; u.rd  = 1'b1; end
      JAL:     u.rd = 1'b1;
      AUIPC:   u.rd = 1'b1;
      LUI:     u.rd = 1'b1;
      default: u = '0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/pipeline_hazard_sequencer_reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, x0 hard-wired clear.
module reg_scoreboard
  import pipeline_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_idx,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_idx,
  input  logic [REG_W-1:0] chk1_idx,
  output logic             chk1_busy_c,
  input  logic [REG_W-1:0] chk2_idx,
  output logic             chk2_busy_c,
  output logic [NREGS-1:0] pending,
  output logic             empty_c
);

  localparam logic [NREGS-1:0] X0_KEEP = {{(NREGS-1){1'b1}}, 1'b0};

  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;
  logic [NREGS-1:0] pending_nxt;

  // Set is applied after clear so a same-bit collision leaves the bit set.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_idx] = 1'b1;
    if (clr_en) clr_mask[clr_idx] = 1'b1;
    pending_nxt = ((pending & ~clr_mask) | set_mask) & X0_KEEP;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) pending <= '0;
    else          pending <= pending_nxt;
  end

  assign chk1_busy_c = pending[chk1_idx];
  assign chk2_busy_c = pending[chk2_idx];
  assign empty_c     = (pending == '0);

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// Central stall/flush sequencer: scoreboard-based hazard stalls, data-memory
// wait freeze, taken-branch squash and FENCE/SYSTEM drain.
module pipeline_hazard_sequencer
  import pipeline_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             if_id_valid,
  input  logic [OPC_W-1:0] if_id_opcode,
  input  logic [REG_W-1:0] if_id_read_reg1,
  input  logic [REG_W-1:0] if_id_read_reg2,
  input  logic [REG_W-1:0] if_id_write_reg,
  input  logic             exe_branch_taken,
  input  logic             mem_req_valid,
  input  logic             mem_ready,
  input  logic             wb_regWrite,
  input  logic [REG_W-1:0] wb_write_reg,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_exe_en,
  output logic             id_exe_bubble,
  output logic             exe_mem_en,
  output logic             mem_wb_bubble,
  output logic             stall,
  output logic [NREGS-1:0] pending,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state;
  state_e           state_nxt;
  reg_use_t         use_c;
  logic             rs1_busy_c;
  logic             rs2_busy_c;
  logic             hazard_c;
  logic             sync_op_c;
  logic             freeze_c;
  logic             issue_c;
  logic             sb_empty_c;
  logic             sb_set_en;
  logic [REG_W-1:0] sb_set_idx;
  logic             sb_clr_en;

  assign use_c     = decode_use(if_id_opcode);
  assign hazard_c  = if_id_valid &&
                     ((use_c.rs1 && rs1_busy_c) || (use_c.rs2 && rs2_busy_c) ||
                      (use_c.rd && pending[if_id_write_reg]));
  assign sync_op_c = if_id_valid &&
                     ((if_id_opcode == FENCES) || (if_id_opcode == SYSCALL));
  // MEM_WAIT freeze covers the cycle the miss is first seen as well.
  assign freeze_c  = !mem_ready && ((state == MEM_WAIT) || mem_req_valid);

  assign issue_c    = if_id_valid && !stall && !if_id_flush && id_exe_en;
  assign sb_set_en  = issue_c && use_c.rd;
  assign sb_set_idx = if_id_write_reg;
  assign sb_clr_en  = wb_regWrite;

  reg_scoreboard u_scoreboard (
    .clock       (clock),
    .reset_n     (reset_n),
    .set_en      (sb_set_en),
    .set_idx     (sb_set_idx),
    .clr_en      (sb_clr_en),
    .clr_idx     (wb_write_reg),
    .chk1_idx    (if_id_read_reg1),
    .chk1_busy_c (rs1_busy_c),
    .chk2_idx    (if_id_read_reg2),
    .chk2_busy_c (rs2_busy_c),
    .pending     (pending),
    .empty_c     (sb_empty_c)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= RUN;
    else          state <= state_nxt;
  end

  // Priority: reset > memory freeze > branch flush > drain/stall > advance.
  always_comb begin
    state_nxt     = state;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_exe_en     = 1'b1;
    id_exe_bubble = 1'b0;
    exe_mem_en    = 1'b1;
    mem_wb_bubble = 1'b0;
    stall         = 1'b0;
    if (!reset_n) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      if_id_flush   = 1'b1;
      id_exe_en     = 1'b0;
      id_exe_bubble = 1'b1;
      exe_mem_en    = 1'b0;
      mem_wb_bubble = 1'b1;
      state_nxt     = RUN;
    end else if (freeze_c) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_exe_en     = 1'b0;
      exe_mem_en    = 1'b0;
      mem_wb_bubble = 1'b1;
      state_nxt     = MEM_WAIT;
    end else if (exe_branch_taken) begin
      if_id_flush   = 1'b1;
      id_exe_bubble = 1'b1;
      state_nxt     = RUN;
    end else if (state == DRAIN) begin
      stall         = 1'b1;
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_exe_bubble = 1'b1;
      if (sb_empty_c) state_nxt = RUN;
    end else if (hazard_c || (sync_op_c && !sb_empty_c)) begin
      stall         = 1'b1;
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_exe_bubble = 1'b1;
      state_nxt     = hazard_c ? RUN : DRAIN;
    end else begin
      state_nxt     = RUN;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                             stall_count <= '0;
    else if (stall && stall_count != CNT_MAX) stall_count <= stall_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Directed-vector bench for pipeline_hazard_sequencer.
module tb_pipeline_hazard_sequencer;
  import pipeline_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        if_id_valid;
  logic [6:0]  if_id_opcode;
  logic [4:0]  if_id_read_reg1;
  logic [4:0]  if_id_read_reg2;
  logic [4:0]  if_id_write_reg;
  logic        exe_branch_taken;
  logic        mem_req_valid;
  logic        mem_ready;
  logic        wb_regWrite;
  logic [4:0]  wb_write_reg;
  logic        pc_en, if_id_en, if_id_flush, id_exe_en;
  logic        id_exe_bubble, exe_mem_en, mem_wb_bubble, stall;
  logic [31:0] pending;
  logic [31:0] stall_count;
  logic [7:0]  outs;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  // {pc_en, if_id_en, if_id_flush, id_exe_en, id_exe_bubble, exe_mem_en, mem_wb_bubble, stall}
  localparam logic [7:0] P_RUN    = 8'b1101_0100;
  localparam logic [7:0] P_STALL  = 8'b0001_1101;
  localparam logic [7:0] P_FREEZE = 8'b0000_0010;
  localparam logic [7:0] P_FLUSH  = 8'b1111_1100;
  localparam logic [7:0] P_RESET  = 8'b0010_1010;

  assign outs = {pc_en, if_id_en, if_id_flush, id_exe_en,
                 id_exe_bubble, exe_mem_en, mem_wb_bubble, stall};

  always #5 clock = ~clock;

  pipeline_hazard_sequencer #(.CNT_W(32)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .if_id_valid      (if_id_valid),
    .if_id_opcode     (if_id_opcode),
    .if_id_read_reg1  (if_id_read_reg1),
    .if_id_read_reg2  (if_id_read_reg2),
    .if_id_write_reg  (if_id_write_reg),
    .exe_branch_taken (exe_branch_taken),
    .mem_req_valid    (mem_req_valid),
    .mem_ready        (mem_ready),
    .wb_regWrite      (wb_regWrite),
    .wb_write_reg     (wb_write_reg),
    .pc_en            (pc_en),
    .if_id_en         (if_id_en),
    .if_id_flush      (if_id_flush),
    .id_exe_en        (id_exe_en),
    .id_exe_bubble    (id_exe_bubble),
    .exe_mem_en       (exe_mem_en),
    .mem_wb_bubble    (mem_wb_bubble),
    .stall            (stall),
    .pending          (pending),
    .stall_count      (stall_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [6:0] op, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] rd);
    if_id_valid     = v;
    if_id_opcode    = op;
    if_id_read_reg1 = r1;
    if_id_read_reg2 = r2;
    if_id_write_reg = rd;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] r);
    wb_regWrite  = we;
    wb_write_reg = r;
  endtask

  task automatic idle();
    set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    set_wb(1'b0, 5'd0);
    exe_branch_taken = 1'b0;
    mem_req_valid    = 1'b0;
    mem_ready        = 1'b1;
  endtask

  // Same-cycle set and clear of one scoreboard bit must never happen.
  always @(posedge clock) begin
    if (reset_n && dut.sb_set_en && dut.sb_clr_en)
      check("sb_set_clr_same_bit", 64'(dut.sb_set_idx == wb_write_reg), 64'(0));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset_n = 1'b0;
    #2;
    check("rst_outs",  64'(outs), 64'(P_RESET));
    check("rst_pend",  64'(pending), 64'(0));
    check("rst_cnt",   64'(stall_count), 64'(0));
    check("rst_state", 64'(dut.state), 64'(0));
    @(negedge clock); reset_n = 1'b1; #1;
    check("run_idle", 64'(outs), 64'(P_RUN));

    // Dependent read on x5
    @(negedge clock); set_id(1'b1, R_TYPE, 5'd1, 5'd2, 5'd5); #1;
    check("dep_c1", 64'(outs), 64'(P_RUN));
    @(negedge clock); set_id(1'b1, R_TYPE, 5'd5, 5'd1, 5'd6); #1;
    check("dep_pend5", 64'(pending), 64'h20);
    check("dep_c2", 64'(outs), 64'(P_STALL));
    @(negedge clock); #1;
    check("dep_c3", 64'(outs), 64'(P_STALL));
    @(negedge clock); set_wb(1'b1, 5'd5); #1;
    check("dep_c4", 64'(outs), 64'(P_STALL));
    @(negedge clock); set_wb(1'b0, 5'd0); #1;
    check("dep_c5", 64'(outs), 64'(P_RUN));
    check("dep_cnt", 64'(stall_count), 64'(3));
    @(negedge clock); idle(); set_wb(1'b1, 5'd6); #1;
    check("dep_pend6", 64'(pending), 64'h40);

    // x0 is never pending nor a hazard
    @(negedge clock); idle(); set_id(1'b1, I_TYPE, 5'd1, 5'd0, 5'd0); #1;
    check("x0_pend_clr", 64'(pending), 64'(0));
    check("x0_c1", 64'(outs), 64'(P_RUN));
    @(negedge clock); set_id(1'b1, R_TYPE, 5'd0, 5'd0, 5'd7); #1;
    check("x0_pend0", 64'(pending), 64'(0));
    check("x0_c2", 64'(outs), 64'(P_RUN));
    @(negedge clock); idle(); set_wb(1'b1, 5'd7); #1;
    check("x0_pend7", 64'(pending), 64'h80);

    // Memory wait with a WB clear and a deferred branch
    @(negedge clock); idle(); set_id(1'b1, R_TYPE, 5'd1, 5'd2, 5'd9); #1;
    check("mw_pre", 64'(outs), 64'(P_RUN));
    @(negedge clock); idle(); mem_req_valid = 1'b1; mem_ready = 1'b0; exe_branch_taken = 1'b1; #1;
    check("mw_a", 64'(outs), 64'(P_FREEZE));
    check("mw_a_pend", 64'(pending), 64'h200);
    @(negedge clock); set_wb(1'b1, 5'd9); #1;
    check("mw_b", 64'(outs), 64'(P_FREEZE));
    check("mw_b_state", 64'(dut.state), 64'(1));
    @(negedge clock); set_wb(1'b0, 5'd0); #1;
    check("mw_c", 64'(outs), 64'(P_FREEZE));
    check("mw_c_pend", 64'(pending), 64'(0));
    @(negedge clock); mem_ready = 1'b1; #1;
    check("mw_d_flush", 64'(outs), 64'(P_FLUSH));
    @(negedge clock); idle(); #1;
    check("mw_e_state", 64'(dut.state), 64'(0));
    check("mw_e", 64'(outs), 64'(P_RUN));
    check("mw_cnt", 64'(stall_count), 64'(3));

    // Branch beats a RAW hazard; then a WAW stall
    @(negedge clock); set_id(1'b1, R_TYPE, 5'd1, 5'd2, 5'd5); #1;
    check("br_pre", 64'(outs), 64'(P_RUN));
    @(negedge clock); set_id(1'b1, R_TYPE, 5'd5, 5'd1, 5'd6); exe_branch_taken = 1'b1; #1;
    check("br_pend", 64'(pending), 64'h20);
    check("br_out", 64'(outs), 64'(P_FLUSH));
    @(negedge clock); exe_branch_taken = 1'b0; set_id(1'b1, I_TYPE, 5'd1, 5'd0, 5'd5); #1;
    check("br_sb_kept", 64'(pending), 64'h20);
    check("waw_out", 64'(outs), 64'(P_STALL));
    check("br_cnt", 64'(stall_count), 64'(3));
    @(negedge clock); idle(); set_wb(1'b1, 5'd5); #1;
    check("waw_cnt", 64'(stall_count), 64'(4));

    // FENCE drains x3 and x7
    @(negedge clock); idle(); set_id(1'b1, R_TYPE, 5'd1, 5'd2, 5'd3); #1;
    check("fn_pre0", 64'(pending), 64'(0));
    @(negedge clock); set_id(1'b1, R_TYPE, 5'd1, 5'd2, 5'd7); #1;
    check("fn_pre1", 64'(outs), 64'(P_RUN));
    @(negedge clock); set_id(1'b1, FENCES, 5'd0, 5'd0, 5'd0); #1;
    check("fn_t0_pend", 64'(pending), 64'h88);
    check("fn_t0", 64'(outs), 64'(P_STALL));
    @(negedge clock); #1;
    check("fn_t1", 64'(outs), 64'(P_STALL));
    check("fn_t1_state", 64'(dut.state), 64'(2));
    @(negedge clock); set_wb(1'b1, 5'd3); #1;
    check("fn_t2", 64'(outs), 64'(P_STALL));
    @(negedge clock); set_wb(1'b0, 5'd0); #1;
    check("fn_t3", 64'(outs), 64'(P_STALL));
    check("fn_t3_pend", 64'(pending), 64'h80);
    @(negedge clock); set_wb(1'b1, 5'd7); #1;
    check("fn_t4", 64'(outs), 64'(P_STALL));
    @(negedge clock); set_wb(1'b0, 5'd0); #1;
    check("fn_t5", 64'(outs), 64'(P_STALL));
    check("fn_t5_pend", 64'(pending), 64'(0));
    @(negedge clock); #1;
    check("fn_t6", 64'(outs), 64'(P_RUN));
    check("fn_t6_state", 64'(dut.state), 64'(0));
    check("fn_cnt", 64'(stall_count), 64'(10));

    // Reset dropped in the middle of MEM_WAIT
    @(negedge clock); idle(); set_id(1'b1, R_TYPE, 5'd1, 5'd2, 5'd4); #1;
    check("rw_pre", 64'(outs), 64'(P_RUN));
    @(negedge clock); idle(); mem_req_valid = 1'b1; mem_ready = 1'b0; #1;
    check("rw_a", 64'(outs), 64'(P_FREEZE));
    check("rw_a_pend", 64'(pending), 64'h10);
    @(negedge clock); #1;
    check("rw_b_state", 64'(dut.state), 64'(1));
    @(negedge clock); reset_n = 1'b0; #1;
    check("rw_outs", 64'(outs), 64'(P_RESET));
    check("rw_state", 64'(dut.state), 64'(0));
    check("rw_pend", 64'(pending), 64'(0));
    check("rw_cnt", 64'(stall_count), 64'(0));
    @(negedge clock); #1;
    check("rw_hold", 64'(outs), 64'(P_RESET));
    @(negedge clock); reset_n = 1'b1; idle(); #1;
    check("rw_release", 64'(outs), 64'(P_RUN));
    check("rw_rel_state", 64'(dut.state), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_sequencer.md
Name: pipeline_hazard_sequencer

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V integer pipeline (IF, ID, EXE, MEM, WB).
- Replaces per-stage write-register comparators with a 32-entry pending-write scoreboard.
- Produces every pipeline-register enable and bubble, honours a multi-cycle data-memory handshake, squashes on a taken branch/jump, and serialises FENCE/SYSTEM instructions.

Parameters:
- CNT_W, 32, width of the stall-cycle performance counter (saturating).

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- if_id_valid  input  1  IF/ID holds a real instruction
- if_id_opcode  input  7  opcode of the instruction in ID
- if_id_read_reg1  input  5  rs1 of the ID instruction
- if_id_read_reg2  input  5  rs2 of the ID instruction
- if_id_write_reg  input  5  rd of the ID instruction
- exe_branch_taken  input  1  EXE resolved a taken branch, JAL or JALR
- mem_req_valid  input  1  EXE/MEM holds a load or store
- mem_ready  input  1  data memory accepts or completes the request this cycle
- wb_regWrite  input  1  WB commits a register write this cycle
- wb_write_reg  input  5  register written by WB
- pc_en  output  1  PC update enable
- if_id_en  output  1  IF/ID load enable
- if_id_flush  output  1  clear IF/ID to a bubble
- id_exe_en  output  1  ID/EXE load enable
- id_exe_bubble  output  1  load a NOP into ID/EXE
- exe_mem_en  output  1  EXE/MEM load enable
- mem_wb_bubble  output  1  load a NOP into MEM/WB
- stall  output  1  ID instruction is held this cycle
- pending  output  32  scoreboard bits; bit 0 is always 0
- stall_count  output  CNT_W  cycles with stall=1 (saturating)

Behaviour:
- Register usage by opcode:
  - rs1 is read by R_TYPE, I_TYPE, STORE, LOAD, BRANCH and JALR.
  - rs2 is read by R_TYPE, STORE and BRANCH.
  - rd is written by R_TYPE, I_TYPE, LOAD, JAL, JALR, AUIPC and LUI.
  - Register x0 is never a hazard and is never marked pending.
- State machine: 2-bit registered state, RUN / MEM_WAIT / DRAIN.
- RUN, hazard detection:
  - raw = rs1 read and pending[rs1], or rs2 read and pending[rs2].
  - waw = rd written and pending[rd].
  - stall = if_id_valid and (raw or waw).
  - When stall=1: pc_en=0, if_id_en=0, id_exe_bubble=1, id_exe_en=1.
- Scoreboard (no same-cycle bypass; the register file is not write-through):
  - Issue occurs when if_id_valid, no stall, no flush and id_exe_en=1. On issue of an instruction with a nonzero rd, pending[rd] is set at the next edge.
  - When wb_regWrite=1 with a nonzero wb_write_reg, pending[wb_write_reg] is cleared at the next edge.
  - Set and clear of the same bit in one cycle cannot occur, because waw blocks the issue. The bench asserts this; if it ever happens, set wins.
  - A reader unblocks the cycle after its WB commit.
- RUN to MEM_WAIT: taken when mem_req_valid=1 and mem_ready=0.
  - In MEM_WAIT: pc_en, if_id_en, id_exe_en and exe_mem_en are 0; mem_wb_bubble=1.
  - Exit to RUN on the first cycle with mem_ready=1. In that cycle the MEM/WB load is a real one, not a bubble.
  - The scoreboard still clears on WB commits while in MEM_WAIT.
- RUN to DRAIN: taken when a FENCES or SYSCALL opcode is valid in ID and the scoreboard is not empty.
  - In DRAIN, stall=1.
  - Return to RUN when pending==0, then issue normally.
- Branch flush:
  - When exe_branch_taken=1 and exe_mem_en=1: if_id_flush=1, id_exe_bubble=1 and pc_en=1 (redirect).
  - The flush overrides stall and DRAIN entry. The squashed ID instruction does not set the scoreboard.
  - During MEM_WAIT the flush is deferred. Because EXE is frozen, exe_branch_taken is held and acts on the exit cycle.
- Priority: reset > MEM_WAIT freeze > branch flush > DRAIN/stall > normal advance.
- Outputs while reset_n=0:
  - All *_en are 0; if_id_flush, id_exe_bubble and mem_wb_bubble are 1; stall=0.
  - State is RUN, pending is 0 and stall_count is 0.
  - A reset in mid-operation abandons MEM_WAIT or DRAIN immediately.
- stall_count increments on each cycle with stall=1 and holds at all-ones.

Decomposition:
- Shared package pipeline_pkg holds:
  - the opcode localparams R_TYPE, I_TYPE, STORE, LOAD, BRANCH, JALR, JAL, AUIPC, LUI, FENCES and SYSCALL;
  - the state encoding RUN=0, MEM_WAIT=1, DRAIN=2.
- One sub-module, reg_scoreboard: 32-bit pending vector with a set port, a clear port, two read-check ports and an empty flag.

Test Plan:
- Dependent read: ADD x5 issues at cycle 1, ADD x6,x5,x1 in ID at cycle 2, WB writes x5 at cycle 4.
  - Response: stall=1 for cycles 2-4, id_exe_bubble=1 on those cycles, issue at cycle 5, stall_count=3.
- x0 ignored: ADDI x0 then a read of x0.
  - Response: no stall, and pending[0] stays 0.
- Memory wait: LW in MEM with mem_ready=0 for 3 cycles.
  - Response: state MEM_WAIT, all four enables 0 and mem_wb_bubble=1 for 3 cycles, back in RUN on the cycle mem_ready=1.
- Branch with hazard: exe_branch_taken=1 in the same cycle as a raw hazard in ID.
  - Response: if_id_flush=1, id_exe_bubble=1, pc_en=1, stall=0, scoreboard unchanged.
- Fence drain: FENCE in ID with pending={x3,x7}, WB commits x3 at t+2 and x7 at t+4.
  - Response: DRAIN with stall=1 until t+5, then issue.
- Reset in MEM_WAIT: drop reset_n mid-wait.
  - Response: state RUN, pending=0 and stall_count=0 immediately; enables 0 while reset is held.
